// File: rtl/if_fetch_buf.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding ROM reads and
// buffers responses in a FIFO for IF/ID. Optional perf counters: `define IF_PERF_CNT_EN.
module if_fetch_buf #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   rsp_addr_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [31:0]   addr_mem_q [FIFO_DEPTH];
  logic [31:0]   inst_mem_q [FIFO_DEPTH];

  logic [31:0]   jump_tgt;
  logic [31:0]   fetch_addr;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW-1:0] occ;
  logic          unused_jaddr_lsb;

  assign unused_jaddr_lsb = ^jump_addr_i[1:0];

  always_comb begin
    jump_tgt   = {jump_addr_i[31:2], 2'b00};
    fetch_addr = jump_en_i ? jump_tgt : pc_q;
    pop        = (count_q != '0) & inst_ready_i;
    // A response landing in a jump cycle belongs to the abandoned path.
    push       = inflight_q & ~jump_en_i;
    occ        = count_q + {{(CW-1){1'b0}}, inflight_q} - {{(CW-1){1'b0}}, pop};
    issue      = rstn & (occ < CW'(FIFO_DEPTH));
  end

  assign rom_req_o    = issue;
  assign rom_addr_o   = fetch_addr;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_mem_q[rd_ptr_q];
  assign inst_addr_o  = addr_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      rsp_addr_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      // With no issue, fetch_addr is either the held pc or the pending jump target.
      pc_q       <= issue ? fetch_addr + 32'd4 : fetch_addr;
      inflight_q <= issue;
      if (issue) rsp_addr_q <= fetch_addr;
      if (jump_en_i) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          addr_mem_q[wr_ptr_q] <= rsp_addr_q;
          inst_mem_q[wr_ptr_q] <= rom_rdata_i;
          wr_ptr_q             <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop)       fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (jump_en_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: directed vector table plus randomized run against a
// delivered-stream reference model. ROM word n holds value n.
module tb_if_fetch_buf;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_buf #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .rom_req_o    (rom_req),
    .rom_addr_o   (rom_addr),
    .rom_rdata_i  (rom_rdata),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o  (fetch_cnt),
    .flush_cnt_o  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word at byte address a is a>>2.
  always @(posedge clk) if (rom_req) rom_rdata <= rom_addr >> 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic j, input logic [31:0] ja, input logic rd);
    @(negedge clk);
    rstn = r; jump_en = j; jump_addr = ja; inst_ready = rd;
    #1;
  endtask

  localparam logic [2:0] M_REQ = 3'b001, M_RAD = 3'b010, M_OUT = 3'b100, M_ALL = 3'b111;

  typedef struct {
    logic        rstn;
    logic        jump;
    logic [31:0] jaddr;
    logic        ready;
    logic [2:0]  chk;
    logic        exp_req;
    logic [31:0] exp_raddr;
    logic        exp_valid;
    logic [31:0] exp_iaddr;
  } vec_t;

  function automatic vec_t mk(logic r, logic j, logic [31:0] ja, logic rd, logic [2:0] c,
                              logic er, logic [31:0] era, logic ev, logic [31:0] eia);
    vec_t v;
    v.rstn = r; v.jump = j; v.jaddr = ja; v.ready = rd; v.chk = c;
    v.exp_req = er; v.exp_raddr = era; v.exp_valid = ev; v.exp_iaddr = eia;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    logic [31:0] exp_next, prev_iaddr, prev_inst;
    logic        prev_jump, prev_stall, j, rd;
    logic [31:0] ja;
    int          idle, pops, jumps;

    rstn = 1'b0; jump_en = 1'b0; jump_addr = '0; inst_ready = 1'b1; rom_rdata = '0;

    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("reset_req", {31'b0, rom_req}, 32'd0);
    chk("reset_valid", {31'b0, inst_valid}, 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_iaddr", inst_addr, 32'd0);

    // Startup, 5-cycle stall and release.
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h00, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h04, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h08, 1, 32'h00));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h0C, 1, 32'h04));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h10, 1, 32'h08));
    for (int k = 0; k < 5; k++) vt.push_back(mk(1, 0, 0, 0, M_ALL, 0, 32'h14, 1, 32'h0C));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h14, 1, 32'h0C));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h18, 1, 32'h10));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h1C, 1, 32'h14));
    // Reset, then jump to 0x100 with 0x8/0xC on the wrong path.
    vt.push_back(mk(0, 0, 0, 1, M_REQ, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, M_REQ, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h00, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h04, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h08, 1, 32'h00));
    vt.push_back(mk(1, 1, 32'h100, 1, M_ALL, 1, 32'h100, 1, 32'h04));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h104, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h108, 1, 32'h100));
    // Back-to-back jumps 0x40 then 0x83 (aligned to 0x80).
    vt.push_back(mk(1, 1, 32'h40, 1, M_ALL, 1, 32'h40, 1, 32'h104));
    vt.push_back(mk(1, 1, 32'h83, 1, M_ALL, 1, 32'h80, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h84, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h88, 1, 32'h80));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h8C, 1, 32'h84));
    // Jump while full: no issue in the jump cycle, target issued next cycle.
    vt.push_back(mk(1, 0, 0, 0, M_ALL, 0, 32'h90, 1, 32'h88));
    vt.push_back(mk(1, 1, 32'h103, 0, M_ALL, 0, 32'h100, 1, 32'h88));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h100, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h104, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h108, 1, 32'h100));
    // PC wrap at the top of the address space.
    vt.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, M_ALL, 1, 32'hFFFF_FFFC, 1, 32'h104));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h00, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h04, 1, 32'hFFFF_FFFC));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h08, 1, 32'h00));
    // Mid-operation reset.
    vt.push_back(mk(0, 0, 0, 1, M_REQ, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, M_ALL, 1, 32'h00, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rstn, vt[i].jump, vt[i].jaddr, vt[i].ready);
      if (vt[i].chk[0]) chk($sformatf("vec%0d_req", i), {31'b0, rom_req}, {31'b0, vt[i].exp_req});
      if (vt[i].chk[1]) chk($sformatf("vec%0d_raddr", i), rom_addr, vt[i].exp_raddr);
      if (vt[i].chk[2]) begin
        chk($sformatf("vec%0d_valid", i), {31'b0, inst_valid}, {31'b0, vt[i].exp_valid});
        if (vt[i].exp_valid) begin
          chk($sformatf("vec%0d_iaddr", i), inst_addr, vt[i].exp_iaddr);
          chk($sformatf("vec%0d_inst", i), inst, vt[i].exp_iaddr >> 2);
        end
      end
    end

    // Randomized run: delivered stream must be sequential from the last jump target.
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    exp_next = 32'h0; prev_jump = 0; prev_stall = 0; prev_iaddr = '0; prev_inst = '0;
    idle = 0; pops = 0; jumps = 0;
    for (int c = 0; c < 3000; c++) begin
      j  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 3) != 0);
      ja = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1023);
      drive(1, j, ja, rd);
      if (prev_jump) chk("rnd_post_jump_bubble", {31'b0, inst_valid}, 32'd0);
      if (prev_stall) begin
        chk("rnd_stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("rnd_stall_iaddr", inst_addr, prev_iaddr);
        chk("rnd_stall_inst", inst, prev_inst);
      end
      if (j) chk("rnd_jump_raddr", rom_addr, {ja[31:2], 2'b00});
      if (inst_valid && rd) begin
        chk("rnd_iaddr", inst_addr, exp_next);
        chk("rnd_inst", inst, exp_next >> 2);
        exp_next = exp_next + 32'd4;
        pops++;
      end
      if (j) begin
        exp_next = {ja[31:2], 2'b00};
        jumps++;
      end
      if (!j && !inst_valid) begin
        idle++;
        chk("rnd_starve_bound", {31'b0, (idle > 2)}, 32'd0);
      end else begin
        idle = 0;
      end
      prev_jump  = j;
      prev_stall = inst_valid & ~rd & ~j;
      prev_iaddr = inst_addr;
      prev_inst  = inst;
    end

`ifdef IF_PERF_CNT_EN
    drive(1, 0, 0, 0);
    chk("perf_fetch_cnt", fetch_cnt, pops);
    chk("perf_flush_cnt", flush_cnt, jumps);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("perf_fetch_cnt_reset", fetch_cnt, 32'd0);
    chk("perf_flush_cnt_reset", flush_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
